// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

  localparam int DEB_PRESCALE_DEF = 32768;
  localparam int DEB_STABLE_DEF   = 10;

  // Counter width able to hold 0..stable
  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, stability counter, registered level and optional edge pulses.
// Latency: 2 sync cycles plus STABLE consecutive differing ticks.
// Backpressure: none; free-running, tick_i acts as the clock enable.
// Optional feature: DEBOUNCE_MULTI_EDGE_EN adds rise_o/fall_o.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE    = DEB_STABLE_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic insig_i,
  output logic outsig_o
`ifdef DEBOUNCE_MULTI_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int            CW       = cnt_width(STABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic          s0_q, s1_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser; resets to the output level so no spurious count starts
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_q <= RESET_VAL;
      s1_q <= RESET_VAL;
    end else begin
      s0_q <= insig_i;
      s1_q <= s0_q;
    end
  end

  // Next-state: count consecutive differing samples, any agreeing sample restarts the count
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (tick_i) begin
      if (s1_q == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        out_d = s1_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and debounced level registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      out_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign outsig_o = out_q;

`ifdef DEBOUNCE_MULTI_EDGE_EN
  logic rise_q, fall_q;

  // Edge pulses registered alongside the level so they coincide with the new outsig
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= ~out_q & out_d;
      fall_q <= out_q & ~out_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample prescaler feeding one debounce_chan per input.
// Latency: between 2+(STABLE-1)*PRESCALE+1 and 2+STABLE*PRESCALE clocks from input change to outsig.
// Backpressure: none; inputs sampled continuously. Optional DEBOUNCE_MULTI_EDGE_EN adds rise_o/fall_o pulses.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS  = 8,
  parameter int                  PRESCALE  = DEB_PRESCALE_DEF,
  parameter int                  STABLE    = DEB_STABLE_DEF,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] insig_i,
  output logic [CHANNELS-1:0] outsig_o
`ifdef DEBOUNCE_MULTI_EDGE_EN
  ,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic tick;

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q;

      // Free-running prescaler 0..PRESCALE-1; tick on the last count
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          pre_q <= '0;
        end else if (pre_q == PRE_LAST) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end

      assign tick = (pre_q == PRE_LAST);
    end else begin : g_nopre
      // Every clock is a sample clock
      assign tick = 1'b1;
    end
  endgenerate

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_chan #(
        .STABLE   (STABLE),
        .RESET_VAL(RESET_VAL[i])
      ) u_chan (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tick_i  (tick),
        .insig_i (insig_i[i]),
        .outsig_o(outsig_o[i])
`ifdef DEBOUNCE_MULTI_EDGE_EN
        ,
        .rise_o  (rise_o[i]),
        .fall_o  (fall_o[i])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: main instance CHANNELS=4/PRESCALE=4/STABLE=3, plus a PRESCALE=1/STABLE=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] insig;
  logic [3:0] outsig;
  logic [0:0] deg_in;
  logic [0:0] deg_out;
`ifdef DEBOUNCE_MULTI_EDGE_EN
  logic [3:0] rise, fall;
  logic [0:0] deg_rise, deg_fall;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  debounce_multi #(
    .CHANNELS (4),
    .PRESCALE (4),
    .STABLE   (3),
    .RESET_VAL(4'b0000)
  ) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .insig_i (insig),
    .outsig_o(outsig)
`ifdef DEBOUNCE_MULTI_EDGE_EN
    ,
    .rise_o  (rise),
    .fall_o  (fall)
`endif
  );

  debounce_multi #(
    .CHANNELS (1),
    .PRESCALE (1),
    .STABLE   (1),
    .RESET_VAL(1'b0)
  ) u_deg (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .insig_i (deg_in),
    .outsig_o(deg_out)
`ifdef DEBOUNCE_MULTI_EDGE_EN
    ,
    .rise_o  (deg_rise),
    .fall_o  (deg_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One active edge, then park on the falling edge for sampling and driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bounded wait for outsig to reach a value; n = edges taken, -1 on timeout
  task automatic wait_out(input logic [3:0] want, output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (outsig == want) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int         n;
    logic [3:0] exp_out;
    logic [3:0] exp_rise;

    rst_n  = 1'b0;
    insig  = 4'b0000;
    deg_in = 1'b0;
    #3;
    check("reset_outsig_async", 32'(outsig), 32'h0);
    repeat (2) @(negedge clk);
    check("reset_outsig", 32'(outsig), 32'h0);
    check("reset_deg_out", 32'(deg_out), 32'h0);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("reset_rise", 32'(rise), 32'h0);
    check("reset_fall", 32'(fall), 32'h0);
`endif

    // Clean edge on ch0, early glitch on ch1, mid-count glitch on ch2 (low for the edge-8 sample)
    rst_n = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      insig[0] = 1'b1;
      insig[1] = (e <= 6);
      insig[2] = (e != 6);
      insig[3] = 1'b0;
      step();
      exp_out  = {1'b0, (e >= 20), 1'b0, (e >= 12)};
      exp_rise = {1'b0, (e == 20), 1'b0, (e == 12)};
      check($sformatf("glitch_outsig_e%0d", e), 32'(outsig), 32'(exp_out));
`ifdef DEBOUNCE_MULTI_EDGE_EN
      check($sformatf("glitch_rise_e%0d", e), 32'(rise), 32'(exp_rise));
      check($sformatf("glitch_fall_e%0d", e), 32'(fall), 32'h0);
`endif
    end

    // Bring all channels high: ticks 28,32,36 after input change before edge 25
    insig = 4'b1111;
    wait_out(4'b1111, n);
    check("all_high_latency", 32'(n), 32'd12);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("all_high_rise", 32'(rise), 32'b1010);
`endif

    // All fall together on the third qualifying tick
    insig = 4'b0000;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (outsig != 4'b1111) begin
        n = i;
        break;
      end
    end
    check("fall_latency", 32'(n), 32'd12);
    check("fall_outsig", 32'(outsig), 32'h0);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("fall_pulse", 32'(fall), 32'b1111);
`endif
    step();
    check("fall_outsig_hold", 32'(outsig), 32'h0);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("fall_pulse_end", 32'(fall), 32'h0);
`endif

    // Rise again, then start a fall and reset with cnt at 2
    insig = 4'b1111;
    wait_out(4'b1111, n);
    check("rehigh_latency", 32'(n), 32'd11);
    insig = 4'b0000;
    repeat (9) step();
    check("pre_reset_outsig", 32'(outsig), 32'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outsig", 32'(outsig), 32'h0);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("midrst_fall", 32'(fall), 32'h0);
`endif
    insig = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      step();
      exp_out = (e >= 12) ? 4'b1111 : 4'b0000;
      if (e == 3 || e == 4 || e == 8 || e == 11 || e == 12 || e == 13)
        check($sformatf("post_rst_outsig_e%0d", e), 32'(outsig), 32'(exp_out));
    end

    // Degenerate instance: exactly three edges from input change to output
    deg_in = 1'b1;
    step();
    check("deg_rise_e1", 32'(deg_out), 32'h0);
    step();
    check("deg_rise_e2", 32'(deg_out), 32'h0);
    step();
    check("deg_rise_e3", 32'(deg_out), 32'h1);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("deg_rise_pulse", 32'(deg_rise), 32'h1);
`endif
    deg_in = 1'b0;
    step();
    check("deg_fall_e1", 32'(deg_out), 32'h1);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("deg_rise_pulse_end", 32'(deg_rise), 32'h0);
`endif
    step();
    check("deg_fall_e2", 32'(deg_out), 32'h1);
    step();
    check("deg_fall_e3", 32'(deg_out), 32'h0);
`ifdef DEBOUNCE_MULTI_EDGE_EN
    check("deg_fall_pulse", 32'(deg_fall), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
